// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type, clog2 helper and FIFO geometry defaults
//   Used by fifo_sink_arbiter, rr_pick and the FIFO wrapper.
package fifo_arb_pkg;

    typedef enum logic {IDLE, STREAM} arb_state_t;

    localparam int FIFO_DEPTH     = 1024;
    localparam int FIFO_MAX_BURST = 16;

    // Smallest r with 2**r >= v; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_sink_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector
//   req   : request vector
//   ptr   : highest-priority index
//   found : any request set
//   index : first set request at or after ptr, wrapping modulo N
module rr_pick import fifo_arb_pkg::*; #(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    int j;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[IW'(j)]) begin
                found = 1'b1;
                index = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_sink_arbiter.sv
// fifo_sink_arbiter: round-robin burst arbiter feeding the platform FIFO sink
//   clock/reset         : FIFO write clock, synchronous active-high reset
//   src_data/valid/ready: N_SRC producer streams (ready is one-hot or zero)
//   snk_data/valid/ready: FIFO Avalon-ST sink
//   fifo_level          : FIFO fill level, gates new grants only
//   grant_valid/grant_id: current grant, id held through IDLE
//   burst_done          : one-cycle pulse after a grant ends
//   beat_count          : free-running count of accepted beats
module fifo_sink_arbiter import fifo_arb_pkg::*; #(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int LEVEL_W   = 11,
    parameter int MAX_BURST = FIFO_MAX_BURST
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]       snk_data,
    output logic                    snk_valid,
    input  logic                    snk_ready,
    input  logic [LEVEL_W-1:0]      fifo_level,
    output logic                    grant_valid,
    output logic [clog2(N_SRC)-1:0] grant_id,
    output logic                    burst_done,
    output logic [31:0]             beat_count
);

    localparam int ID_W  = clog2(N_SRC);
    localparam int CNT_W = clog2(MAX_BURST + 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(DEPTH - MAX_BURST);
    localparam logic [CNT_W-1:0]   BURST_LAST = CNT_W'(MAX_BURST);

    arb_state_t       state, state_next;
    logic [ID_W-1:0]  rr_ptr, pick_index;
    logic [CNT_W-1:0] burst_cnt;
    logic             pick_found, eligible, accept, grant_end;

    rr_pick #(.N(N_SRC), .IW(ID_W)) u_pick (
        .req   (src_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_index)
    );

    assign grant_valid = state == STREAM;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Handshakes are masked during reset so a beat offered in the reset cycle
    // is neither taken by the FIFO nor counted.
    always_comb begin
        state_next = state;
        src_ready  = '0;
        snk_valid  = 1'b0;
        snk_data   = '0;
        eligible   = pick_found && fifo_level <= LEVEL_MAX;
        accept     = 1'b0;
        grant_end  = 1'b0;
        if (state == IDLE) begin
            if (eligible) state_next = STREAM;
        end else begin
            snk_data            = src_data[int'(grant_id) * DATA_W +: DATA_W];
            snk_valid           = src_valid[grant_id] && !reset;
            src_ready[grant_id] = snk_ready && !reset;
            accept              = snk_valid && snk_ready;
            grant_end           = !src_valid[grant_id] || (accept && burst_cnt + 1'b1 == BURST_LAST);
            if (grant_end) state_next = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            burst_cnt  <= '0;
            burst_done <= 1'b0;
            beat_count <= '0;
        end else begin
            burst_done <= grant_end;
            if (state == IDLE && eligible) begin
                grant_id  <= pick_index;
                burst_cnt <= '0;
            end
            if (accept) begin
                burst_cnt  <= burst_cnt + 1'b1;
                beat_count <= beat_count + 1'b1;
            end
            if (grant_end)
                rr_ptr <= (grant_id == ID_W'(N_SRC - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_sink_arbiter.sv
// tb_fifo_sink_arbiter: scoreboard bench with a transaction-level reference model
module tb_fifo_sink_arbiter;

    localparam int N     = 4;
    localparam int IW    = 2;
    localparam int DW    = 32;
    localparam int LW    = 11;
    localparam int MB    = 16;
    localparam int DEPTH = 1024;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [DW-1:0]   snk_data;
    logic            snk_valid;
    logic            snk_ready;
    logic [LW-1:0]   fifo_level;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;
    logic            burst_done;
    logic [31:0]     beat_count;

    fifo_sink_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .snk_data    (snk_data),
        .snk_valid   (snk_valid),
        .snk_ready   (snk_ready),
        .fifo_level  (fifo_level),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .burst_done  (burst_done),
        .beat_count  (beat_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [31:0] d;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    bd_seen  = 0;

    bit          m_busy = 0;
    bit          m_bd   = 0;
    int          m_g    = 0;
    int          m_n    = 0;
    int          m_ptr  = 0;
    logic [31:0] m_cnt  = 0;

    bit          e_gv, e_bd, e_sv;
    int          e_gid;
    logic [31:0] e_cnt;
    logic [N-1:0] e_ready;

    logic [DW-1:0] sd [N];
    int  rem  [N];
    int  seq  [N];
    bit  drop [N];
    int  rdy_mode = 0;
    bit  rdy_tog  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a grant is a burst of up to MB beats from one source,
    // chosen by rotating search, opened only when level leaves room for MB beats.
    always @(negedge clock) begin
        bit v, acc, hit;
        e_gv    = m_busy;
        e_gid   = m_g;
        e_bd    = m_bd;
        e_cnt   = m_cnt;
        e_sv    = m_busy && !reset && src_valid[IW'(m_g)];
        e_ready = (m_busy && !reset && snk_ready) ? (N'(1) << m_g) : '0;
        if (reset) begin
            m_busy = 0; m_bd = 0; m_g = 0; m_n = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_busy) begin
            v   = src_valid[IW'(m_g)];
            acc = v && snk_ready;
            if (acc) begin
                exp_q.push_back('{m_g, sd[IW'(m_g)]});
                m_cnt++;
                m_n++;
            end
            m_bd = !v || (acc && m_n == MB);
            if (m_bd) begin
                m_busy = 0;
                m_ptr  = (m_g + 1) % N;
            end
        end else begin
            m_bd = 0;
            hit  = 0;
            if (src_valid != 0 && int'(fifo_level) <= DEPTH - MB) begin
                for (int k = 0; k < N; k++)
                    if (!hit && src_valid[IW'((m_ptr + k) % N)]) begin
                        hit = 1;
                        m_g = (m_ptr + k) % N;
                    end
                m_busy = 1;
                m_n    = 0;
            end
        end
    end

    always @(negedge clock) begin
        beat_t b;
        #1;
        chk("grant_valid", grant_valid, e_gv);
        chk("grant_id", grant_id, e_gid);
        chk("burst_done", burst_done, e_bd);
        chk("beat_count", beat_count, e_cnt);
        chk("src_ready", src_ready, e_ready);
        chk("snk_valid", snk_valid, e_sv);
        if (!e_gv) chk("idle_data", snk_data, 0);
        if (burst_done) bd_seen++;
        if (snk_valid && snk_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got id %0d data 0x%0h, want no beat", grant_id, snk_data);
            end else begin
                b = exp_q.pop_front();
                chk("beat_id", grant_id, b.id);
                chk("beat_data", snk_data, b.d);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            sd[i] = (32'(i) << 16) + 32'h100 + 32'(seq[i]);
            src_valid[IW'(i)] = rem[i] > 0 && !drop[i];
        end
        src_data = {sd[3], sd[2], sd[1], sd[0]};
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clock);
        acc = src_valid & src_ready;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[IW'(i)]) begin
                seq[i]++;
                if (rem[i] > 0) rem[i]--;
            end
        rdy_tog   = !rdy_tog;
        snk_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? rdy_tog : 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic drain(input int lim);
        int c;
        c = 0;
        while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && c < lim) begin
            tick();
            c++;
        end
        chk("drain_in_time", c < lim, 1);
    endtask

    initial begin
        int bd0, s0, c;
        snk_ready  = 1'b1;
        fifo_level = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; seq[i] = 0; drop[i] = 0;
        end
        drive();
        repeat (2) tick();
        reset = 1'b0;
        tick();

        bd0 = bd_seen;
        rem[2] = 40;
        drive();
        drain(200);
        repeat (3) tick();
        chk("single_src_bursts", bd_seen - bd0, 3);
        chk("single_src_beats", beat_count, 40);

        for (int i = 0; i < N; i++) rem[i] = 1000;
        drive();
        repeat (90) tick();
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive();
        repeat (3) tick();

        rdy_mode = 1;
        s0 = seq[1];
        rem[1] = 16;
        drive();
        drain(200);
        rdy_mode = 0;
        repeat (3) tick();
        chk("backpressure_beats", seq[1] - s0, 16);

        fifo_level = LW'(DEPTH - MB + 1);
        rem[0] = 5;
        drive();
        repeat (20) tick();
        chk("gate_hold", grant_valid, 0);
        fifo_level = LW'(DEPTH - MB);
        tick();
        chk("gate_open", grant_valid, 1);
        drain(100);
        fifo_level = '0;
        repeat (3) tick();

        rem[2] = 1;
        drive();
        drain(50);
        repeat (2) tick();
        rem[3] = 5;
        rem[0] = 8;
        drive();
        drain(200);
        repeat (3) tick();

        s0 = seq[1];
        rem[1] = 30;
        drive();
        c = 0;
        while (seq[1] - s0 < 7 && c < 100) begin
            tick();
            c++;
        end
        chk("reset_reach_beat7", c < 100, 1);
        reset  = 1'b1;
        rem[0] = 3;
        drive();
        tick();
        reset = 1'b0;
        chk("reset_beat_count", beat_count, 0);
        chk("reset_grant_valid", grant_valid, 0);
        tick();
        chk("restart_grant_id", grant_id, 0);
        chk("restart_grant_valid", grant_valid, 1);
        drain(200);
        repeat (3) tick();

        rdy_mode = 2;
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < N; i++) begin
                drop[i] = $urandom_range(0, 9) == 0;
                if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = $urandom_range(1, 40);
            end
            fifo_level = LW'($urandom_range(1000, 1015));
            reset      = $urandom_range(0, 199) == 0;
            drive();
            tick();
        end
        reset    = 1'b0;
        rdy_mode = 0;
        fifo_level = '0;
        for (int i = 0; i < N; i++) drop[i] = 0;
        drive();
        drain(3000);
        repeat (4) tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
